// File: rtl/evo_servo_ramp_pkg.sv
// Shared constants, state encoding and reset defaults for the evo_servo ramp stage.
// Imported by the frame-tick sub-module and the ramp top level.
package evo_servo_ramp_pkg;

  // CSR offsets from EVO_RAMP_ADDR
  localparam logic [1:0] RAMP_SEL    = 2'd0;
  localparam logic [1:0] RAMP_TARGET = 2'd1;
  localparam logic [1:0] RAMP_STEP   = 2'd2;
  localparam logic [1:0] RAMP_STATUS = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ramp_state_t;

  localparam int          DEF_NUM_SERVOS = 13;
  localparam int          DEF_PERIOD_US  = 20000;
  localparam logic [7:0]  DEF_RAMP_ADDR  = 8'h50;
  localparam logic [15:0] DEF_CENTER_PW  = 16'd1500;
  localparam logic [15:0] DEF_MIN_PW     = 16'd500;
  localparam logic [15:0] DEF_MAX_PW     = 16'd2500;
  localparam logic [7:0]  DEF_STEP       = 8'd0;
  localparam logic [4:0]  DEF_SEL        = 5'd0;

  function automatic logic [15:0] clamp_pw(input logic [15:0] v,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/evo_servo_ramp_if.sv
// CSR bus and private pulse-width write port of the ramp stage, bundled for one-line hookup.
//
// Handshake: waitrequest is always 0, so every avs_csr_read/avs_csr_write strobe is
// accepted in the cycle it is high; an addressed read answers with readdatavalid=1 exactly
// one cycle later. priv_wr_pw is a one-cycle valid with no ready: evo_servo takes every
// pulse, and priv_index/priv_pw are meaningful only while priv_wr_pw=1.
interface evo_servo_ramp_if #(
  parameter int CSR_AWIDTH = 8,
  parameter int CSR_DWIDTH = 32
);
  logic [CSR_AWIDTH-1:0] avs_csr_address;
  logic                  avs_csr_read;
  logic                  avs_csr_write;
  logic [CSR_DWIDTH-1:0] avs_csr_writedata;
  logic [CSR_DWIDTH-1:0] avs_csr_readdata;
  logic                  avs_csr_readdatavalid;
  logic                  avs_csr_waitrequest;
  logic                  priv_wr_pw;
  logic [4:0]            priv_index;
  logic [15:0]           priv_pw;

  modport master (
    output avs_csr_address, avs_csr_read, avs_csr_write, avs_csr_writedata,
    input  avs_csr_readdata, avs_csr_readdatavalid, avs_csr_waitrequest,
    input  priv_wr_pw, priv_index, priv_pw
  );

  modport slave (
    input  avs_csr_address, avs_csr_read, avs_csr_write, avs_csr_writedata,
    output avs_csr_readdata, avs_csr_readdatavalid, avs_csr_waitrequest,
    output priv_wr_pw, priv_index, priv_pw
  );
endinterface

// File: rtl/evo_servo_ramp_tick.sv
// Frame timer for the ramp stage: counts en1mhz strobes, and holds at most one frame
// tick that lands while a scan is still running.
module evo_servo_ramp_tick
  import evo_servo_ramp_pkg::*;
#(
  parameter int PERIOD_US = DEF_PERIOD_US
) (
  input  logic clk,
  input  logic reset,
  input  logic en1mhz,
  input  logic busy,
  output logic scan_start,
  output logic pending
);

  localparam int CW = (PERIOD_US > 2) ? $clog2(PERIOD_US) : 1;

  logic [CW-1:0] cnt;
  logic          frame_tick;

  assign frame_tick = en1mhz && (cnt == CW'(PERIOD_US - 1));

  // A tick arriving together with a held one collapses into a single scan.
  assign scan_start = !busy && (frame_tick || pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (en1mhz) begin
        cnt <= frame_tick ? '0 : cnt + 1'b1;
      end
      if (busy && frame_tick) begin
        pending <= 1'b1;
      end else if (!busy) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/evo_servo_ramp.sv
// Motion-profile stage ahead of evo_servo: once per frame, walks every active servo's
// pulse width one programmed step toward its CSR target and emits a private write pulse.
module evo_servo_ramp
  import evo_servo_ramp_pkg::*;
#(
  parameter int          NUM_SERVOS    = DEF_NUM_SERVOS,
  parameter logic [7:0]  EVO_RAMP_ADDR = DEF_RAMP_ADDR,
  parameter int          PERIOD_US     = DEF_PERIOD_US,
  parameter logic [15:0] CENTER_PW     = DEF_CENTER_PW,
  parameter logic [15:0] MIN_PW        = DEF_MIN_PW,
  parameter logic [15:0] MAX_PW        = DEF_MAX_PW,
  parameter int          CSR_AWIDTH    = 8,
  parameter int          CSR_DWIDTH    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en1mhz,
  evo_servo_ramp_if.slave   bus,
  output ramp_state_t       dbg_state,
  output logic [4:0]        dbg_idx,
  output logic              dbg_pending
);

  localparam int IW = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

  ramp_state_t                   state;
  logic [4:0]                    idx;
  logic [4:0]                    sel;
  logic [15:0]                   cur     [NUM_SERVOS];
  logic [15:0]                   tgt     [NUM_SERVOS];
  logic [7:0]                    step_pw [NUM_SERVOS];
  logic [NUM_SERVOS-1:0]         active;

  logic                          busy;
  logic                          scan_start;
  logic                          pending;
  logic [IW-1:0]                 idx_n;
  logic [IW-1:0]                 sel_n;

  assign busy  = (state == SCAN);
  assign idx_n = idx[IW-1:0];
  assign sel_n = sel[IW-1:0];

  evo_servo_ramp_tick #(
    .PERIOD_US (PERIOD_US)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .en1mhz     (en1mhz),
    .busy       (busy),
    .scan_start (scan_start),
    .pending    (pending)
  );

  // ---------------------------------------------------------------- CSR decode
  logic [CSR_AWIDTH-1:0] addr_off;
  logic                  hit;
  logic [1:0]            reg_sel;
  logic                  sel_ok;
  logic [CSR_DWIDTH-1:0] wd;
  logic                  unused_wd;
  logic                  wr_sel;
  logic                  wr_tgt;
  logic                  wr_step;
  logic                  rd_hit;
  logic [CSR_DWIDTH-1:0] rd_data;

  assign addr_off  = bus.avs_csr_address - CSR_AWIDTH'(EVO_RAMP_ADDR);
  assign hit       = (addr_off < CSR_AWIDTH'(4));
  assign reg_sel   = addr_off[1:0];
  assign sel_ok    = ({1'b0, sel} < 6'(NUM_SERVOS));
  assign wd        = bus.avs_csr_writedata;
  assign unused_wd = ^wd[CSR_DWIDTH-1:16];

  assign wr_sel  = bus.avs_csr_write && hit && (reg_sel == RAMP_SEL);
  assign wr_tgt  = bus.avs_csr_write && hit && (reg_sel == RAMP_TARGET) && sel_ok;
  assign wr_step = bus.avs_csr_write && hit && (reg_sel == RAMP_STEP) && sel_ok;
  assign rd_hit  = bus.avs_csr_read && hit;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      RAMP_SEL:    rd_data[4:0] = sel;
      RAMP_TARGET: if (sel_ok) rd_data[15:0] = tgt[sel_n];
      RAMP_STEP:   if (sel_ok) rd_data[7:0] = step_pw[sel_n];
      RAMP_STATUS: rd_data[NUM_SERVOS-1:0] = active;
      default:     rd_data = '0;
    endcase
  end

  // ---------------------------------------------------------- step arithmetic
  logic [15:0] cur_i;
  logic [15:0] tgt_i;
  logic [7:0]  step_i;
  logic [16:0] diff;
  logic [16:0] mag;
  logic        snap;
  logic [15:0] next_pw;

  assign cur_i  = cur[idx_n];
  assign tgt_i  = tgt[idx_n];
  assign step_i = step_pw[idx_n];

  // diff is the signed 17-bit distance tgt - cur; bit 16 set means moving down.
  assign diff    = {1'b0, tgt_i} - {1'b0, cur_i};
  assign mag     = diff[16] ? (~diff + 17'd1) : diff;
  assign snap    = (step_i == 8'd0) || (mag <= {9'd0, step_i});
  assign next_pw = snap     ? tgt_i :
                   diff[16] ? (cur_i - {8'd0, step_i}) :
                              (cur_i + {8'd0, step_i});

  // ------------------------------------------------- state, arrays, outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state                     <= IDLE;
      idx                       <= 5'd0;
      sel                       <= DEF_SEL;
      active                    <= '0;
      bus.priv_wr_pw            <= 1'b0;
      bus.priv_index            <= 5'd0;
      bus.priv_pw               <= 16'd0;
      bus.avs_csr_readdata      <= '0;
      bus.avs_csr_readdatavalid <= 1'b0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
        cur[i]     <= CENTER_PW;
        tgt[i]     <= CENTER_PW;
        step_pw[i] <= DEF_STEP;
      end
    end else begin
      bus.priv_wr_pw <= 1'b0;

      case (state)
        IDLE: begin
          if (scan_start) begin
            state <= SCAN;
            idx   <= 5'd0;
          end
        end
        SCAN: begin
          if (active[idx_n]) begin
            cur[idx_n]     <= next_pw;
            bus.priv_wr_pw <= 1'b1;
            bus.priv_index <= idx;
            bus.priv_pw    <= next_pw;
            if (snap) begin
              active[idx_n] <= 1'b0;
            end
          end
          if (idx == 5'(NUM_SERVOS - 1)) begin
            state <= IDLE;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // CSR writes come after the scan so a same-cycle TARGET write re-arms the servo.
      if (wr_sel) begin
        sel <= wd[4:0];
      end
      if (wr_tgt) begin
        tgt[sel_n]    <= clamp_pw(wd[15:0], MIN_PW, MAX_PW);
        active[sel_n] <= 1'b1;
      end
      if (wr_step) begin
        step_pw[sel_n] <= wd[7:0];
      end

      bus.avs_csr_readdatavalid <= rd_hit;
      bus.avs_csr_readdata      <= rd_hit ? rd_data : '0;
    end
  end

  assign bus.avs_csr_waitrequest = 1'b0;

  assign dbg_state   = state;
  assign dbg_idx     = idx;
  assign dbg_pending = pending;

endmodule

// File: tb/tb_evo_servo_ramp.sv
// Bench for evo_servo_ramp: directed and random CSR traffic, with expected write pulses
// derived per frame from a plain arithmetic model of the ramp rules.
module tb_evo_servo_ramp;
  import evo_servo_ramp_pkg::*;

  localparam int         NS     = 13;
  localparam int         PERIOD = 20;
  localparam logic [7:0] BASE   = 8'h50;

  // ---------------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        en1mhz;
  ramp_state_t dbg_state;
  logic [4:0]  dbg_idx;
  logic        dbg_pending;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  evo_servo_ramp_if #(.CSR_AWIDTH(8), .CSR_DWIDTH(32)) bus ();

  evo_servo_ramp #(
    .NUM_SERVOS    (NS),
    .EVO_RAMP_ADDR (BASE),
    .PERIOD_US     (PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en1mhz      (en1mhz),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .dbg_idx     (dbg_idx),
    .dbg_pending (dbg_pending)
  );

  // ------------------------------------------------------------- bookkeeping
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  int unsigned m_cur [NS];
  int unsigned m_tgt [NS];
  int unsigned m_step[NS];
  bit          m_active[NS];
  int unsigned m_sel;
  int          m_ticks;

  function automatic int unsigned m_clamp(input int unsigned v);
    if (v < 500)  return 500;
    if (v > 2500) return 2500;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_cur[k] = 1500; m_tgt[k] = 1500; m_step[k] = 0; m_active[k] = 0;
    end
    m_sel   = 0;
    m_ticks = 0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    for (int k = 0; k < NS; k++) s[k] = m_active[k];
    return s;
  endfunction

  // scoreboard: {cycle, index, pw} of every pulse the frame should produce
  logic [52:0] exp_q[$];

  // Frame ticked in cycle c: servo k is updated one step and its pulse shows in c+2+k.
  task automatic model_frame(input int c);
    for (int k = 0; k < NS; k++) begin
      if (m_active[k]) begin
        int d  = int'(m_tgt[k]) - int'(m_cur[k]);
        int ad = (d < 0) ? -d : d;
        if (m_step[k] == 0 || ad <= int'(m_step[k])) begin
          m_cur[k]    = m_tgt[k];
          m_active[k] = 0;
        end else if (d > 0) begin
          m_cur[k] = m_cur[k] + m_step[k];
        end else begin
          m_cur[k] = m_cur[k] - m_step[k];
        end
        exp_q.push_back({32'(c + 2 + k), 5'(k), 16'(m_cur[k])});
      end
    end
  endtask

  task automatic model_write(input logic [1:0] off, input logic [31:0] d);
    case (off)
      2'd0: m_sel = d[4:0];
      2'd1: if (m_sel < NS) begin m_tgt[m_sel] = m_clamp(d[15:0]); m_active[m_sel] = 1; end
      2'd2: if (m_sel < NS) m_step[m_sel] = d[7:0];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return 32'(m_sel);
      2'd1:    return (m_sel < NS) ? 32'(m_tgt[m_sel]) : 32'd0;
      2'd2:    return (m_sel < NS) ? 32'(m_step[m_sel]) : 32'd0;
      default: return m_status();
    endcase
  endfunction

  // ------------------------------------------------------------ pulse monitor
  logic [52:0] act_pulse;
  logic [52:0] exp_pulse;

  always @(negedge clk) begin
    if (bus.priv_wr_pw === 1'b1) begin
      act_pulse = {32'(cyc), bus.priv_index, bus.priv_pw};
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_pulse observed idx=%0d pw=%0d cycle=%0d expected=none",
               bus.priv_index, bus.priv_pw, cyc);
      end
      if (exp_q.size() != 0) begin
        exp_pulse = exp_q.pop_front();
        check("pulse{cyc,idx,pw}", 64'(act_pulse), 64'(exp_pulse));
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_en(input bit apply, output bit wrapped);
    int c = cyc;
    en1mhz = 1'b1;
    step_clk();
    en1mhz = 1'b0;
    m_ticks++;
    wrapped = 1'b0;
    if (m_ticks == PERIOD) begin
      m_ticks = 0;
      wrapped = 1'b1;
      if (apply) model_frame(c);
    end
  endtask

  task automatic run_frame();
    bit w = 1'b0;
    for (int i = 0; i < PERIOD && !w; i++) pulse_en(1'b1, w);
    repeat (NS + 3) step_clk();
  endtask

  task automatic csr_write(input logic [1:0] off, input logic [31:0] d);
    bus.avs_csr_address   = BASE + 8'(off);
    bus.avs_csr_writedata = d;
    bus.avs_csr_write     = 1'b1;
    step_clk();
    bus.avs_csr_write     = 1'b0;
    model_write(off, d);
  endtask

  task automatic csr_read_check(input logic [1:0] off, input string tag);
    logic [31:0] exp = model_read(off);
    bus.avs_csr_address = BASE + 8'(off);
    bus.avs_csr_read    = 1'b1;
    step_clk();
    bus.avs_csr_read    = 1'b0;
    check({tag, "_valid"}, 64'(bus.avs_csr_readdatavalid), 64'd1);
    check(tag, 64'(bus.avs_csr_readdata), 64'(exp));
  endtask

  // Drive every active servo straight to its target so later frames start quiet.
  task automatic settle_all();
    for (int k = 0; k < NS; k++) begin
      if (m_active[k]) begin
        csr_write(2'd0, 32'(k));
        csr_write(2'd2, 32'd0);
      end
    end
    run_frame();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit          w;
    int unsigned t_first;
    int unsigned t_new;

    reset                 = 1'b1;
    en1mhz                = 1'b0;
    bus.avs_csr_address   = '0;
    bus.avs_csr_read      = 1'b0;
    bus.avs_csr_write     = 1'b0;
    bus.avs_csr_writedata = '0;
    model_reset();
    repeat (3) step_clk();

    check("rst_priv_wr_pw",  64'(bus.priv_wr_pw), 64'd0);
    check("rst_priv_index",  64'(bus.priv_index), 64'd0);
    check("rst_priv_pw",     64'(bus.priv_pw), 64'd0);
    check("rst_rdvalid",     64'(bus.avs_csr_readdatavalid), 64'd0);
    check("rst_readdata",    64'(bus.avs_csr_readdata), 64'd0);
    check("rst_waitrequest", 64'(bus.avs_csr_waitrequest), 64'd0);
    check("rst_state",       64'(dbg_state), 64'(IDLE));
    check("rst_pending",     64'(dbg_pending), 64'd0);
    reset = 1'b0;
    step_clk();

    csr_read_check(2'd3, "rst_status");
    csr_read_check(2'd0, "rst_sel");
    csr_read_check(2'd1, "rst_target");
    csr_read_check(2'd2, "rst_step");

    // ramp up: servo 3, 40 us per frame, 1500 -> 1600 over three frames
    csr_write(2'd0, 32'd3);
    csr_write(2'd2, 32'd40);
    csr_write(2'd1, 32'd1600);
    csr_read_check(2'd3, "ramp_status_set");
    run_frame();
    run_frame();
    run_frame();
    csr_read_check(2'd3, "ramp_status_done");
    check("scan_end_idx", 64'(dbg_idx), 64'(NS - 1));

    // jump with clamp: 100 becomes 500 in one frame
    csr_write(2'd0, 32'd0);
    csr_write(2'd2, 32'd0);
    csr_write(2'd1, 32'd100);
    csr_read_check(2'd1, "clamp_target");
    run_frame();
    csr_read_check(2'd3, "clamp_status");

    // collision: TARGET write to servo 2 in the very cycle servo 2 is scanned and snaps
    settle_all();
    t_first = (m_cur[2] > 1500) ? m_cur[2] - 30  : m_cur[2] + 30;
    t_new   = (m_cur[2] > 1500) ? m_cur[2] - 400 : m_cur[2] + 400;
    csr_write(2'd0, 32'd2);
    csr_write(2'd2, 32'd50);
    csr_write(2'd1, 32'(t_first));
    w = 1'b0;
    for (int i = 0; i < PERIOD && m_ticks != PERIOD - 1; i++) pulse_en(1'b1, w);
    pulse_en(1'b1, w);
    check("collision_wrap_seen", 64'(w), 64'd1);
    repeat (2) step_clk();
    csr_write(2'd1, 32'(t_new));
    repeat (NS + 2) step_clk();
    csr_read_check(2'd3, "collision_status");
    run_frame();
    csr_read_check(2'd3, "collision_status_after");

    // random traffic, including SEL values past the last servo
    for (int it = 0; it < 8; it++) begin
      csr_write(2'd0, 32'($urandom_range(0, 15)));
      csr_write(2'd2, 32'($urandom_range(0, 200)));
      csr_write(2'd1, 32'($urandom_range(0, 3000)));
      csr_read_check(2'd1, "rand_target");
      csr_read_check(2'd2, "rand_step");
      repeat ($urandom_range(1, 3)) run_frame();
      csr_read_check(2'd3, "rand_status");
    end

    // out-of-range selector: writes ignored, reads zero, no pulses
    settle_all();
    csr_write(2'd0, 32'd20);
    csr_write(2'd1, 32'd1000);
    csr_write(2'd2, 32'd9);
    csr_read_check(2'd3, "oor_status");
    csr_read_check(2'd1, "oor_target");
    csr_read_check(2'd2, "oor_step");
    csr_read_check(2'd0, "oor_sel");
    run_frame();

    // reset in the cycle servo 5 is being evaluated: its pulse never appears
    csr_write(2'd0, 32'd5);
    csr_write(2'd2, 32'd10);
    csr_write(2'd1, 32'd2000);
    csr_write(2'd0, 32'd8);
    csr_write(2'd2, 32'd10);
    csr_write(2'd1, 32'd900);
    w = 1'b0;
    for (int i = 0; i < PERIOD && !w; i++) pulse_en(1'b0, w);
    repeat (5) step_clk();
    check("midscan_state", 64'(dbg_state), 64'(SCAN));
    reset = 1'b1;
    step_clk();
    check("midscan_rst_wr_pw", 64'(bus.priv_wr_pw), 64'd0);
    check("midscan_rst_state", 64'(dbg_state), 64'(IDLE));
    step_clk();
    reset = 1'b0;
    model_reset();
    step_clk();
    csr_read_check(2'd3, "post_rst_status");
    csr_read_check(2'd0, "post_rst_sel");
    csr_read_check(2'd1, "post_rst_target");
    run_frame();

    // CSR isolation: addresses outside the window stay silent
    bus.avs_csr_address = BASE + 8'd4;
    bus.avs_csr_read    = 1'b1;
    step_clk();
    bus.avs_csr_read    = 1'b0;
    check("iso_hi_valid", 64'(bus.avs_csr_readdatavalid), 64'd0);
    check("iso_hi_data",  64'(bus.avs_csr_readdata), 64'd0);
    bus.avs_csr_address = BASE - 8'd1;
    bus.avs_csr_read    = 1'b1;
    step_clk();
    bus.avs_csr_read    = 1'b0;
    check("iso_lo_valid", 64'(bus.avs_csr_readdatavalid), 64'd0);
    check("iso_lo_data",  64'(bus.avs_csr_readdata), 64'd0);
    csr_read_check(2'd0, "iso_sel_after");
    step_clk();
    check("idle_readdata", 64'(bus.avs_csr_readdata), 64'd0);

    repeat (5) step_clk();
    check("pulses_outstanding", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
